// File: rtl/register_skid_sync_rst.sv
`default_nettype none
// ============================================================================
// Module   : register_skid_sync_rst
// Brief    : Two-entry valid/ready skid buffer with synchronous clear.
//            Holds up to two beats in a main register (drives out_data) and
//            a skid register. All outputs come straight from flops, and
//            there is no combinational path from out_ready to in_ready.
// Ports    : clk        - clock, rising edge
//            rst        - synchronous active-high reset
//            flush      - synchronous clear of buffered beats
//            in_data    - upstream payload [WIDTH-1:0]
//            in_valid   - upstream beat valid
//            in_ready   - stage can accept a beat (registered)
//            out_data   - downstream payload (main register)
//            out_valid  - main register holds a beat (registered)
//            out_ready  - downstream accepts
//            occupancy  - held beats: 0, 1 or 2 (state flops)
// Revision : 1.0 - initial release
// ============================================================================
module register_skid_sync_rst #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       occupancy
);

  // Encoding chosen so the state value equals the number of held beats.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_BUSY  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;
  logic             r_out_valid;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_main_nxt;
  logic [WIDTH-1:0] w_skid_nxt;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & r_in_ready;
  assign w_out_fire = r_out_valid & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;
    if (flush) begin
      // Flush wins over any handshake this cycle; an accepted input beat is
      // discarded while a concurrent out_fire is simply consumed downstream.
      w_state_nxt = S_EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_main_nxt  = in_data;
            w_state_nxt = S_BUSY;
          end
        end
        S_BUSY: begin
          if (w_in_fire && w_out_fire) begin
            w_main_nxt = in_data;
          end else if (w_in_fire) begin
            // Downstream stalled: park the new beat behind the main one.
            w_skid_nxt  = in_data;
            w_state_nxt = S_FULL;
          end else if (w_out_fire) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          // in_ready is low here, so only the drain side can move.
          if (w_out_fire) begin
            w_main_nxt  = r_skid;
            w_state_nxt = S_BUSY;
          end
        end
        default: begin
          w_state_nxt = S_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_EMPTY;
      r_main      <= '0;
      r_skid      <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_main      <= w_main_nxt;
      r_skid      <= w_skid_nxt;
      // Ready and valid are loaded from the next state so both stay pure
      // flop outputs.
      r_in_ready  <= (w_state_nxt != S_FULL);
      r_out_valid <= (w_state_nxt != S_EMPTY);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_main;
  assign occupancy = r_state;

endmodule
`default_nettype wire
